de0_sw_debounce: RTL and testbench
==================================

DE0_SW_DEBOUNCE -- requirements
Module: de0_sw_debounce

Interface
REQ-001 Parameter WIDTH, default 10, number of switch bits.
REQ-002 Parameter STABLE_CYCLES, default 500000, consecutive clk cycles of disagreement needed to accept a new level (10 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw_raw  input  WIDTH  asynchronous, bouncing board switch levels.
REQ-006 sw_out  output  WIDTH  debounced, registered levels; drives the switch PIO in_port.
REQ-007 sw_rise  output  WIDTH  one-cycle pulse per bit when that bit of sw_out goes 0->1.
REQ-008 sw_fall  output  WIDTH  one-cycle pulse per bit when that bit of sw_out goes 1->0.
REQ-009 sw_change  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits, registered with them.

Function
REQ-010 Each sw_raw bit SHALL pass through a 2-flop synchroniser; the second-stage value is sw_sync.
REQ-011 Each bit SHALL have an independent counter of width ceil(log2(STABLE_CYCLES+1)) bits.
REQ-012 Per-bit states: STABLE (sw_sync == sw_out bit) and PENDING (sw_sync != sw_out bit).
REQ-013 In STABLE, the counter SHALL be held at 0.
REQ-014 In PENDING, the counter SHALL increment by 1 per cycle.
REQ-015 When sw_sync agrees with sw_out again before acceptance (bounce), the counter SHALL clear to 0 on that edge and sw_out SHALL stay unchanged.
REQ-016 Acceptance: on the edge where sw_sync still disagrees and the counter equals STABLE_CYCLES-1, sw_out SHALL take sw_sync and the counter SHALL clear to 0.
REQ-017 Latency: a clean level change on sw_raw SHALL appear on sw_out exactly STABLE_CYCLES+2 clk edges after the first edge that samples it.
REQ-018 sw_rise/sw_fall SHALL be registered and asserted in the same cycle sw_out changes, for exactly one cycle.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1; no wrap-around is possible.
REQ-020 Bits SHALL be fully independent; simultaneous acceptance on several bits SHALL produce all corresponding pulses in the same cycle and a single-cycle sw_change.
REQ-021 sw_rise and sw_fall SHALL never both be set for the same bit in the same cycle.
REQ-022 A glitch shorter than STABLE_CYCLES cycles after synchronisation SHALL never alter sw_out or pulse any output.

Reset
REQ-023 While reset is high on a clk edge: synchroniser flops, sw_out, all counters, sw_rise, sw_fall and sw_change SHALL become 0.
REQ-024 Reset asserted mid-PENDING SHALL discard the partial count; counting SHALL restart from 0 after release.
REQ-025 After release with a switch held high, that bit SHALL be accepted STABLE_CYCLES+2 edges later with a sw_rise pulse.
REQ-026 No output SHALL depend combinationally on sw_raw or reset.

Verification (benches override STABLE_CYCLES=4, WIDTH=10)
REQ-027 Reset, then sw_raw=10'h001 held -> sw_out=10'h001 on the 6th edge after the first sample edge; sw_rise=10'h001 and sw_change=1 for that one cycle only.
REQ-028 sw_out=10'h001, sw_raw bit0 low for 3 cycles then high -> sw_out stays 10'h001, no pulses.
REQ-029 sw_raw bit0 bounces 0/1/0/1 each cycle, then steady 1 -> sw_out bit0 rises 6 edges after the last transition, exactly one sw_rise.
REQ-030 sw_out=10'h000, sw_raw 10'h000->10'h3FF on one edge -> sw_out=10'h3FF in one cycle, sw_rise=10'h3FF, single sw_change pulse.
REQ-031 sw_out=10'h3FF, sw_raw=10'h000, reset pulsed after 2 pending cycles -> all outputs 0 in the cycle after reset, no sw_fall pulses.
REQ-032 sw_out=10'h200, sw_raw=10'h000 held -> sw_fall=10'h200 for one cycle, sw_out=10'h000.

Source files
------------

// File: rtl/de0_sw_debounce.sv
// rtl/de0_sw_debounce.sv - per-bit synchronising debouncer for DE0 slide switches
//
// Purpose:
//   Each switch bit is synchronised with two flops, then compared with its
//   accepted (debounced) level. While the synchronised level disagrees, a
//   per-bit counter runs; a new level is accepted only after STABLE_CYCLES
//   consecutive cycles of disagreement. Any agreement in between clears the
//   counter, so bounces and short glitches never reach the outputs.
//
// Ports:
//   clk        in   1      system clock, all state updates on the rising edge
//   reset      in   1      synchronous, active-high reset
//   sw_raw     in   WIDTH  raw, asynchronous, bouncing switch levels
//   sw_out     out  WIDTH  debounced, registered switch levels
//   sw_rise    out  WIDTH  one-cycle pulse when a bit of sw_out goes 0->1
//   sw_fall    out  WIDTH  one-cycle pulse when a bit of sw_out goes 1->0
//   sw_change  out  1      one-cycle pulse, OR of all sw_rise/sw_fall bits
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  cycles of sustained disagreement needed to accept a level
//                  (legal range 2 .. 2^24-1)

module de0_sw_debounce #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  // Counter value on the edge where the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages; r_sync2 is the synchronised level (sw_sync).
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Accepted levels and the edge pulses registered alongside them.
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_change;

  // Per-bit disagreement counters.
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // PENDING state per bit: synchronised level differs from accepted level.
  logic [WIDTH-1:0] w_pending;
  // Acceptance this edge: still pending and the count has run its course.
  logic [WIDTH-1:0] w_accept;

  always_comb begin
    w_pending = r_sync2 ^ r_out;
    w_accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_pending[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  // Counters: held at 0 while STABLE, cleared on a bounce back to agreement
  // and on acceptance, so they never pass CNT_LAST and cannot wrap.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt[gi] <= '0;
      end else if (!w_pending[gi] || w_accept[gi]) begin
        r_cnt[gi] <= '0;
      end else begin
        r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_out    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
    end else begin
      r_sync1  <= sw_raw;
      r_sync2  <= r_sync1;
      // Accepted bits take the synchronised level; the rest hold.
      r_out    <= (r_out & ~w_accept) | (r_sync2 & w_accept);
      // An accepted bit always disagreed with r_out, so its new level alone
      // tells the direction; rise and fall are mutually exclusive per bit.
      r_rise   <= w_accept & r_sync2;
      r_fall   <= w_accept & ~r_sync2;
      r_change <= |w_accept;
    end
  end

  assign sw_out    = r_out;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign sw_change = r_change;

endmodule

// File: tb/tb_de0_sw_debounce.sv
// tb/tb_de0_sw_debounce.sv - directed self-checking bench for de0_sw_debounce

module tb_de0_sw_debounce;

  localparam int WIDTH         = 10;
  localparam int STABLE_CYCLES = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_change;

  int n_checks;
  int n_fail;

  de0_sw_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_out   (sw_out),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_change(sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] raw);
    sw_raw = raw;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset('0);
    n_checks++;
    if (sw_out !== 10'h000) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", sw_out, 10'h000);
    end
    n_checks++;
    if ({sw_rise, sw_fall, sw_change} !== 21'h0) begin
      n_fail++; $display("FAIL reset_pulses: rise %h fall %h chg %b want all 0", sw_rise, sw_fall, sw_change);
    end
  endtask

  // Clean rise on bit 0: accepted on the 6th edge after the first sample edge.
  task automatic test_rise_latency();
    sw_raw = 10'h001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        n_checks++;
        if (sw_out !== 10'h000 || sw_change !== 1'b0) begin
          n_fail++; $display("FAIL rise_early edge %0d: out %h chg %b want 000 0", k, sw_out, sw_change);
        end
      end else begin
        n_checks++;
        if (sw_out !== 10'h001) begin
          n_fail++; $display("FAIL rise_out: got %h want %h", sw_out, 10'h001);
        end
        n_checks++;
        if (sw_rise !== 10'h001 || sw_fall !== 10'h000 || sw_change !== 1'b1) begin
          n_fail++; $display("FAIL rise_pulse: rise %h fall %h chg %b want 001 000 1", sw_rise, sw_fall, sw_change);
        end
      end
    end
    tick();
    n_checks++;
    if (sw_out !== 10'h001 || sw_rise !== 10'h000 || sw_change !== 1'b0) begin
      n_fail++; $display("FAIL rise_one_cycle: out %h rise %h chg %b want 001 000 0", sw_out, sw_rise, sw_change);
    end
  endtask

  // Bit 0 low for 3 cycles (shorter than STABLE_CYCLES) must be ignored.
  task automatic test_glitch();
    int bad;
    bad = 0;
    sw_raw = 10'h000;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) sw_raw = 10'h001;
      if (sw_out !== 10'h001 || sw_rise !== '0 || sw_fall !== '0 || sw_change !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL glitch: %0d disturbed cycles, out %h want 001 and no pulses", bad, sw_out);
    end
  endtask

  // Clean fall on bit 0 back to all-zero.
  task automatic test_fall_bit0();
    sw_raw = 10'h000;
    for (int k = 1; k <= 5; k++) tick();
    n_checks++;
    if (sw_out !== 10'h001 || sw_fall !== 10'h000) begin
      n_fail++; $display("FAIL fall0_early: out %h fall %h want 001 000", sw_out, sw_fall);
    end
    tick();
    n_checks++;
    if (sw_out !== 10'h000 || sw_fall !== 10'h001 || sw_rise !== 10'h000 || sw_change !== 1'b1) begin
      n_fail++; $display("FAIL fall0: out %h fall %h rise %h chg %b want 000 001 000 1", sw_out, sw_fall, sw_rise, sw_change);
    end
  endtask

  // Bit 0 toggles every cycle, then holds high: rise 6 edges after last change.
  task automatic test_bounce();
    int rises;
    rises = 0;
    sw_raw = 10'h001; tick(); rises += sw_rise[0];
    sw_raw = 10'h000; tick(); rises += sw_rise[0];
    sw_raw = 10'h001; tick(); rises += sw_rise[0];
    sw_raw = 10'h000; tick(); rises += sw_rise[0];
    sw_raw = 10'h001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rises += sw_rise[0];
      if (k == 5) begin
        n_checks++;
        if (sw_out !== 10'h000) begin
          n_fail++; $display("FAIL bounce_early: out %h want 000", sw_out);
        end
      end
    end
    n_checks++;
    if (sw_out !== 10'h001 || sw_rise !== 10'h001) begin
      n_fail++; $display("FAIL bounce_accept: out %h rise %h want 001 001", sw_out, sw_rise);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      rises += sw_rise[0];
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++; $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
  endtask

  // All bits change on one edge: accepted together, single sw_change pulse.
  task automatic test_all_rise();
    int changes;
    changes = 0;
    do_reset('0);
    sw_raw = 10'h3FF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      changes += sw_change;
    end
    n_checks++;
    if (sw_out !== 10'h000) begin
      n_fail++; $display("FAIL all_early: out %h want 000", sw_out);
    end
    tick();
    changes += sw_change;
    n_checks++;
    if (sw_out !== 10'h3FF || sw_rise !== 10'h3FF || sw_fall !== 10'h000 || sw_change !== 1'b1) begin
      n_fail++; $display("FAIL all_accept: out %h rise %h fall %h chg %b want 3ff 3ff 000 1", sw_out, sw_rise, sw_fall, sw_change);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      changes += sw_change;
    end
    n_checks++;
    if (changes != 1 || sw_rise !== 10'h000) begin
      n_fail++; $display("FAIL all_change_count: got %0d rise %h want 1 000", changes, sw_rise);
    end
  endtask

  // Reset after 2 pending cycles of a full fall: outputs cleared, no sw_fall.
  task automatic test_reset_mid_pending();
    int falls;
    falls = 0;
    sw_raw = 10'h000;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sw_fall !== '0) falls++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (sw_out !== 10'h000 || sw_rise !== '0 || sw_fall !== '0 || sw_change !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: out %h rise %h fall %h chg %b want all 0", sw_out, sw_rise, sw_fall, sw_change);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (sw_fall !== '0 || sw_out !== '0) falls++;
    end
    n_checks++;
    if (falls != 0) begin
      n_fail++; $display("FAIL midrst_no_fall: %0d bad cycles want 0", falls);
    end
  endtask

  // Partial count discarded by reset; held-high switch accepted 6 edges after release.
  task automatic test_reset_restart();
    sw_raw = 10'h001;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    n_checks++;
    if (sw_out !== 10'h000 || sw_rise !== 10'h000) begin
      n_fail++; $display("FAIL restart_early: out %h rise %h want 000 000", sw_out, sw_rise);
    end
    tick();
    n_checks++;
    if (sw_out !== 10'h001 || sw_rise !== 10'h001 || sw_change !== 1'b1) begin
      n_fail++; $display("FAIL restart_accept: out %h rise %h chg %b want 001 001 1", sw_out, sw_rise, sw_change);
    end
  endtask

  // MSB fall from 10'h200 to 10'h000.
  task automatic test_fall_msb();
    do_reset('0);
    sw_raw = 10'h200;
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if (sw_out !== 10'h200) begin
      n_fail++; $display("FAIL msb_setup: out %h want 200", sw_out);
    end
    sw_raw = 10'h000;
    for (int k = 1; k <= 6; k++) tick();
    n_checks++;
    if (sw_out !== 10'h000 || sw_fall !== 10'h200 || sw_rise !== 10'h000 || sw_change !== 1'b1) begin
      n_fail++; $display("FAIL msb_fall: out %h fall %h rise %h chg %b want 000 200 000 1", sw_out, sw_fall, sw_rise, sw_change);
    end
    tick();
    n_checks++;
    if (sw_fall !== 10'h000 || sw_change !== 1'b0) begin
      n_fail++; $display("FAIL msb_one_cycle: fall %h chg %b want 000 0", sw_fall, sw_change);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    sw_raw   = '0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall_bit0();
    test_bounce();
    test_all_rise();
    test_reset_mid_pending();
    test_reset_restart();
    test_fall_msb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
